remote_update_sequencer: RTL and testbench
==========================================

// Module: remote_update_sequencer
//
// PURPOSE
// - Drives the FPGA internal-reconfiguration interface (cfg_ENA/cfg_CBSEL/cfg_CONFIG)
//   for the golden image's top level. Turns a one-shot image request into a timed,
//   glitch-free setup/pulse/wait sequence.
// - Samples cfg_ERROR and reports a failed reconfiguration as a sticky error.
// - Sits between the top-level request logic (buttons/LED control) and the cfg_* pins.
//
// PARAMETERS
// - SETUP_CYC    16         cycles cfg_ENA/cfg_CBSEL are stable before cfg_CONFIG rises
// - PULSE_CYC    64         cycles cfg_CONFIG is held high
// - TIMEOUT_CYC  1000000    cycles waited in WAIT before declaring failure
// - CNT_W        20         counter width; must hold max(SETUP_CYC,PULSE_CYC,TIMEOUT_CYC)-1
// - GOLDEN_SEL   2'b00      CBSEL value of the golden image
//
// PORTS
// - clk           in   1  system clock; all logic is on this clock
// - rstn          in   1  asynchronous active-low reset
// - req_valid     in   1  image-load request
// - req_sel       in   2  requested image (CBSEL value); sampled on accept
// - req_ready     out  1  1 only in IDLE; accept = req_valid & req_ready
// - cfg_ERROR     in   1  asynchronous error from the config block; 2-flop synchronized
// - cfg_ENA       out  1  reconfiguration enable
// - cfg_CBSEL     out  2  image select
// - cfg_CONFIG    out  1  reconfiguration trigger
// - busy          out  1  1 in every state except IDLE
// - err_flag      out  1  sticky failure indication
// - state_o       out  3  encoded state for LEDs: IDLE=0 SETUP=1 PULSE=2 WAIT=3 FAIL=4
//
// BEHAVIOUR
// - Reset (async, rstn=0): state=IDLE, cfg_ENA=0, cfg_CBSEL=GOLDEN_SEL, cfg_CONFIG=0,
//   err_flag=0, busy=0, req_ready=1 once released, counter=0, sync flops=0.
//   Reset mid-sequence aborts immediately; all outputs are registered, no glitches.
// - IDLE: on accept, latch req_sel, clear err_flag, counter=0, go to SETUP.
//   Outputs change on the clock edge after accept (1-cycle latency).
// - SETUP: cfg_ENA=1, cfg_CBSEL=latched sel, cfg_CONFIG=0, for exactly SETUP_CYC
//   cycles (counter 0..SETUP_CYC-1), then PULSE. Synchronized error is ignored here.
// - PULSE: cfg_CONFIG=1 for exactly PULSE_CYC cycles, then WAIT.
//   A synchronized error goes to FAIL.
// - WAIT: cfg_CONFIG=0, cfg_ENA=1. A synchronized error goes to FAIL. When the counter
//   reaches TIMEOUT_CYC-1 the state also goes to FAIL; a successful device
//   reconfiguration never returns here.
// - FAIL: one cycle, err_flag<=1 (held until next accept), cfg_ENA=0, cfg_CONFIG=0,
//   cfg_CBSEL holds, then IDLE.
// - Simultaneous error and counter terminal count in PULSE/WAIT: error wins (goes to FAIL).
// - req_valid while busy is not accepted and is not queued.
// - The counter resets to 0 on every state change and does not wrap within a state.
//
// CONFIGURATION
// - RU_GOLDEN_RETRY_EN defined: if FAIL is entered and latched sel != GOLDEN_SEL, latch
//   GOLDEN_SEL, keep err_flag=1, and go directly to SETUP (one automatic fallback). A
//   failure on the golden attempt goes to IDLE. Port retry_o (out, 1) is added; it is 1
//   from the fallback until the next accept or reset.
// - RU_GOLDEN_RETRY_EN undefined: FAIL always goes to IDLE; there is no retry_o port.
//
// TESTING (SETUP_CYC=4, PULSE_CYC=8, TIMEOUT_CYC=32)
// - Reset values: rstn=0 -> ENA=0, CONFIG=0, CBSEL=00, busy=0, err_flag=0.
// - Normal load: accept sel=2'b10 at cycle 0 -> ENA=1, CBSEL=10 from cycle 1;
//   CONFIG=1 in cycles 5..12; WAIT from cycle 13.
// - Error in WAIT: cfg_ERROR=1 at cycle 15 -> FAIL 2 sync cycles later; err_flag=1;
//   ENA=0; IDLE next; err_flag cleared on next accept.
// - Timeout: no error -> FAIL after 32 WAIT cycles, err_flag=1; req_valid during busy
//   is ignored.
// - Async reset asserted during PULSE -> CONFIG=0 and ENA=0 with no clock edge; IDLE.
// - RU_GOLDEN_RETRY_EN: sel=01 fails -> retry_o=1, CBSEL=00, full SETUP/PULSE again;
//   a second failure -> IDLE.

Source files
------------

// File: rtl/remote_update_sequencer.sv
// Remote-update sequencer: turns a one-shot image request into a timed cfg_ENA/cfg_CBSEL/cfg_CONFIG
// setup/pulse/wait sequence with sticky failure report. Optional fallback to golden: RU_GOLDEN_RETRY_EN.
module remote_update_sequencer #(
    parameter int unsigned SETUP_CYC   = 16,
    parameter int unsigned PULSE_CYC   = 64,
    parameter int unsigned TIMEOUT_CYC = 1000000,
    parameter int unsigned CNT_W       = 20,
    parameter logic [1:0]  GOLDEN_SEL  = 2'b00
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       req_valid,
    input  logic [1:0] req_sel,
    output logic       req_ready,
    input  logic       cfg_ERROR,
    output logic       cfg_ENA,
    output logic [1:0] cfg_CBSEL,
    output logic       cfg_CONFIG,
    output logic       busy,
    output logic       err_flag,
    output logic [2:0] state_o
`ifdef RU_GOLDEN_RETRY_EN
    ,
    output logic       retry_o
`endif
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SETUP = 3'd1,
        S_PULSE = 3'd2,
        S_WAIT  = 3'd3,
        S_FAIL  = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] SETUP_LAST   = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] PULSE_LAST   = CNT_W'(PULSE_CYC - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic             err_meta_p0;
    logic             err_sync_p1;
    logic             accept;
`ifdef RU_GOLDEN_RETRY_EN
    logic             fallback;
`endif

    assign accept  = req_valid & req_ready;
    assign state_o = state_q;

    // Two-flop synchronizer for the asynchronous config-block error
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            err_meta_p0 <= 1'b0;
            err_sync_p1 <= 1'b0;
        end else begin
            err_meta_p0 <= cfg_ERROR;
            err_sync_p1 <= err_meta_p0;
        end
    end

    always_comb begin
        state_d = state_q;
`ifdef RU_GOLDEN_RETRY_EN
        fallback = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (accept) state_d = S_SETUP;
            end
            S_SETUP: begin
                if (cnt_q == SETUP_LAST) state_d = S_PULSE;
            end
            S_PULSE: begin
                if (err_sync_p1)                  state_d = S_FAIL;
                else if (cnt_q == PULSE_LAST)     state_d = S_WAIT;
            end
            S_WAIT: begin
                if (err_sync_p1 || cnt_q == TIMEOUT_LAST) state_d = S_FAIL;
            end
            S_FAIL: begin
`ifdef RU_GOLDEN_RETRY_EN
                // A failed non-golden image gets exactly one automatic golden attempt
                if (cfg_CBSEL != GOLDEN_SEL) begin
                    fallback = 1'b1;
                    state_d  = S_SETUP;
                end else begin
                    state_d = S_IDLE;
                end
`else
                state_d = S_IDLE;
`endif
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (state_d != state_q)
                cnt_q <= '0;
            else if (state_q != S_IDLE && cnt_q != {CNT_W{1'b1}})
                cnt_q <= cnt_q + 1'b1;
        end
    end

    // Outputs are decoded from the next state and registered, so pins never glitch
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cfg_ENA    <= 1'b0;
            cfg_CONFIG <= 1'b0;
            cfg_CBSEL  <= GOLDEN_SEL;
            busy       <= 1'b0;
            req_ready  <= 1'b1;
            err_flag   <= 1'b0;
        end else begin
            cfg_ENA    <= (state_d == S_SETUP) || (state_d == S_PULSE) || (state_d == S_WAIT);
            cfg_CONFIG <= (state_d == S_PULSE);
            busy       <= (state_d != S_IDLE);
            req_ready  <= (state_d == S_IDLE);
            if (accept)
                cfg_CBSEL <= req_sel;
`ifdef RU_GOLDEN_RETRY_EN
            else if (fallback)
                cfg_CBSEL <= GOLDEN_SEL;
`endif
            if (accept)
                err_flag <= 1'b0;
            else if (state_d == S_FAIL)
                err_flag <= 1'b1;
        end
    end

`ifdef RU_GOLDEN_RETRY_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            retry_o <= 1'b0;
        else if (accept)
            retry_o <= 1'b0;
        else if (fallback)
            retry_o <= 1'b1;
    end
`endif

endmodule

// File: tb/tb_remote_update_sequencer.sv
// Scoreboard bench for remote_update_sequencer: per-attempt phase lengths predicted from request
// and error timing, compared against attempts reconstructed from the pins by a monitor.
module tb_remote_update_sequencer;

    localparam int S = 4;
    localparam int P = 8;
    localparam int T = 32;
    localparam logic [1:0] GOLD = 2'b00;
`ifdef RU_GOLDEN_RETRY_EN
    localparam bit RETRY_BUILD = 1'b1;
`else
    localparam bit RETRY_BUILD = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       req_valid = 1'b0;
    logic [1:0] req_sel = 2'b00;
    logic       cfg_ERROR = 1'b0;
    logic       req_ready, cfg_ENA, cfg_CONFIG, busy, err_flag;
    logic [1:0] cfg_CBSEL;
    logic [2:0] state_o;
`ifdef RU_GOLDEN_RETRY_EN
    logic       retry_o;
`endif

    int checks = 0;
    int failures = 0;
    bit mon_en = 1'b0;

    always #5 clk = ~clk;

    remote_update_sequencer #(
        .SETUP_CYC(S), .PULSE_CYC(P), .TIMEOUT_CYC(T), .CNT_W(20), .GOLDEN_SEL(GOLD)
    ) dut (
        .clk(clk), .rstn(rstn),
        .req_valid(req_valid), .req_sel(req_sel), .req_ready(req_ready),
        .cfg_ERROR(cfg_ERROR), .cfg_ENA(cfg_ENA), .cfg_CBSEL(cfg_CBSEL), .cfg_CONFIG(cfg_CONFIG),
        .busy(busy), .err_flag(err_flag), .state_o(state_o)
`ifdef RU_GOLDEN_RETRY_EN
        , .retry_o(retry_o)
`endif
    );

    typedef struct {
        logic [1:0] sel;
        int         setup;
        int         pulse;
        int         wt;
        int         fail;
        logic       err_start;
        logic       err_after;
        logic       busy_after;
        logic       retry;
    } att_t;

    att_t exp_q[$];

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Reference: error pulse visible to the sequencer in cycle e (0 = none), cycles counted from accept
    function automatic void predict(input logic [1:0] sel, input int e);
        att_t a;
        a.sel = sel; a.setup = S; a.fail = 1;
        a.err_start = 1'b0; a.err_after = 1'b1; a.retry = 1'b0;
        if (e > S && e <= S + P) begin
            a.pulse = e - S; a.wt = 0;
        end else if (e > S + P && e <= S + P + T) begin
            a.pulse = P; a.wt = e - S - P;
        end else begin
            a.pulse = P; a.wt = T;
        end
        a.busy_after = RETRY_BUILD && (sel != GOLD);
        exp_q.push_back(a);
        if (a.busy_after) begin
            a.sel = GOLD; a.pulse = P; a.wt = T;
            a.err_start = 1'b1; a.retry = 1'b1; a.busy_after = 1'b0;
            exp_q.push_back(a);
        end
    endfunction

    // Monitor: rebuilds each attempt from the pins and scores it against the queue
    att_t cur;
    bit   in_att = 1'b0;
    bit   sel_bad, rdy_bad, st_bad;

    task automatic finish_att();
        att_t x;
        if (exp_q.size() == 0) begin
            chk("unexpected_attempt", 1, 0);
        end else begin
            x = exp_q.pop_front();
            chk("sel", cur.sel, x.sel);
            chk("setup_len", cur.setup, x.setup);
            chk("pulse_len", cur.pulse, x.pulse);
            chk("wait_len", cur.wt, x.wt);
            chk("fail_len", cur.fail, x.fail);
            chk("err_at_start", cur.err_start, x.err_start);
            chk("err_after_fail", cur.err_after, x.err_after);
            chk("busy_after_fail", cur.busy_after, x.busy_after);
`ifdef RU_GOLDEN_RETRY_EN
            chk("retry_o", cur.retry, x.retry);
`endif
            chk("cbsel_stable", sel_bad, 0);
            chk("ready_low_when_busy", rdy_bad, 0);
            chk("state_code", st_bad, 0);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (!mon_en) begin
                in_att = 1'b0;
            end else begin
                if (in_att && (!busy || (cur.fail > 0 && cfg_ENA))) begin
                    cur.busy_after = busy;
                    cur.err_after  = err_flag;
                    finish_att();
                    in_att = 1'b0;
                end
                if (busy) begin
                    if (!in_att) begin
                        in_att = 1'b1;
                        cur.sel = cfg_CBSEL;
                        cur.setup = 0; cur.pulse = 0; cur.wt = 0; cur.fail = 0;
                        cur.err_start = err_flag;
`ifdef RU_GOLDEN_RETRY_EN
                        cur.retry = retry_o;
`else
                        cur.retry = 1'b0;
`endif
                        sel_bad = 1'b0; rdy_bad = 1'b0; st_bad = 1'b0;
                    end
                    if (cfg_CBSEL != cur.sel) sel_bad = 1'b1;
                    if (req_ready) rdy_bad = 1'b1;
                    if (!cfg_ENA) begin
                        cur.fail++;
                        if (cfg_CONFIG || state_o != 3'd4) st_bad = 1'b1;
                    end else if (cfg_CONFIG) begin
                        cur.pulse++;
                        if (state_o != 3'd2) st_bad = 1'b1;
                    end else if (cur.pulse == 0) begin
                        cur.setup++;
                        if (state_o != 3'd1) st_bad = 1'b1;
                    end else begin
                        cur.wt++;
                        if (state_o != 3'd3) st_bad = 1'b1;
                    end
                end
            end
        end
    end

    task automatic wait_ready();
        int n = 0;
        while (!req_ready && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) chk("ready_timeout", 0, 1);
    endtask

    // One request; e is the cycle in which the synchronized error is seen (0 = no error)
    task automatic run_txn(input logic [1:0] sel, input int e);
        int k;
        k = (e >= 3) ? e - 2 : 0;
        wait_ready();
        req_valid = 1'b1;
        req_sel   = sel;
        @(posedge clk);
        predict(sel, e);
        for (int c = 1; c < 600; c++) begin
            @(negedge clk);
            cfg_ERROR = (c == k);
            req_valid = (c >= 2 && c <= 5);
            req_sel   = 2'($urandom);
            if (c > 6 && c > k && req_ready) break;
        end
        cfg_ERROR = 1'b0;
        req_valid = 1'b0;
    endtask

    initial begin
        int m, e, n;
        logic [1:0] s;

        repeat (2) @(negedge clk);
        chk("reset_ena", cfg_ENA, 0);
        chk("reset_config", cfg_CONFIG, 0);
        chk("reset_cbsel", cfg_CBSEL, 0);
        chk("reset_busy", busy, 0);
        chk("reset_err", err_flag, 0);
        chk("reset_state", state_o, 0);
        rstn = 1'b1;
        @(negedge clk);
        chk("ready_after_reset", req_ready, 1);
        mon_en = 1'b1;

        run_txn(2'b10, 0);
        run_txn(2'b11, 17);
        run_txn(2'b01, S + P);
        run_txn(2'b00, S + 1);
        run_txn(2'b10, 3);
        run_txn(2'b01, S + P + T);
        run_txn(2'b00, 0);
        for (int i = 0; i < 10; i++) begin
            s = 2'($urandom);
            m = $urandom_range(0, 3);
            case (m)
                1:       e = $urandom_range(3, S);
                2:       e = $urandom_range(S + 1, S + P);
                3:       e = $urandom_range(S + P + 1, S + P + T);
                default: e = 0;
            endcase
            run_txn(s, e);
        end
        repeat (3) @(negedge clk);
        chk("scoreboard_drained", exp_q.size(), 0);

        mon_en = 1'b0;
        wait_ready();
        req_valid = 1'b1;
        req_sel   = 2'b11;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        n = 0;
        while (!cfg_CONFIG && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("pulse_reached", cfg_CONFIG, 1);
        #2 rstn = 1'b0;
        #1;
        chk("async_config", cfg_CONFIG, 0);
        chk("async_ena", cfg_ENA, 0);
        chk("async_busy", busy, 0);
        chk("async_state", state_o, 0);
        chk("async_cbsel", cfg_CBSEL, 0);
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        chk("ready_after_async", req_ready, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
